// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encodings, completer register offsets, CTRL bit indices
package apb_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_state_e;
  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_SCRATCH0 = 5'h04;
  localparam logic [4:0] OFF_SCRATCH1 = 5'h08;
  localparam logic [4:0] OFF_ID       = 5'h0C;
  localparam logic [4:0] OFF_CNT      = 5'h10;
  localparam logic [4:0] OFF_WAITCFG  = 5'h14;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_OVF = 2;
  localparam int CTRL_IE  = 3;
  // Unmapped or misaligned offsets, and writes to read-only registers, get PSLVERR
  function automatic logic addr_err(input logic [4:0] a, input logic w);
    return a[1:0] != 2'b00 || a > OFF_WAITCFG || (w && (a == OFF_ID || a == OFF_CNT));
  endfunction
endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: loadable 4-bit wait-state down-counter, advances only on PCLKEN
module apb_wait_counter (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       PCLKEN,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt <= '0;
    else if (PCLKEN) cnt <= load ? load_val : (dec && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/apb3_reg_completer.sv
// apb3_reg_completer: APB3 completer with CTRL/scratch/ID/counter registers and wait states
module apb3_reg_completer
  import apb_pkg::*;
#(
  parameter int          ADDRWIDTH = 16,
  parameter int          DATAWIDTH = 32,
  parameter logic [31:0] ID_VALUE  = 32'hA3B0_0001,
  parameter int          CNTWIDTH  = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic                 PREADY,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PSLVERR,
  output logic                 IRQ
);
  apb_state_e state, state_nx;
  logic [4:0] addr_q;
  logic write_q;
  logic [31:0] wdata_q, scratch0, scratch1, rdata;
  logic [3:0] waitcfg;
  logic [CNTWIDTH-1:0] cnt;
  logic en, ie, ovf, zero, load, dec, step, abort, err, wr, wr_ctrl, ovf_set;
  logic unused_paddr;
  assign unused_paddr = ^PADDR[ADDRWIDTH-1:5];
  apb_wait_counter u_wait (
    .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN),
    .load(load), .dec(dec), .load_val(waitcfg), .zero(zero)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    load     = state == IDLE && PCLKEN && PSEL && !PENABLE;
    abort    = state == ACCESS && PCLKEN && !PSEL;
    step     = state == ACCESS && PCLKEN && PSEL && PENABLE;
    dec      = step && !zero;
    state_nx = load ? ACCESS : (abort || (step && zero)) ? IDLE : state;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (load) begin
      addr_q  <= PADDR[4:0];
      write_q <= PWRITE;
      wdata_q <= 32'(PWDATA);
    end
  assign err     = addr_err(addr_q, write_q);
  assign wr      = step && zero && write_q && !err;
  assign wr_ctrl = wr && addr_q == OFF_CTRL;
  assign ovf_set = en && &cnt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      ovf      <= 1'b0;
      IRQ      <= 1'b0;
      scratch0 <= '0;
      scratch1 <= '0;
      waitcfg  <= '0;
      cnt      <= '0;
    end else begin
      cnt <= (wr_ctrl && wdata_q[CTRL_CLR]) ? '0 : en ? cnt + CNTWIDTH'(1) : cnt;
      // A wrap in the same cycle as a W1C keeps OVF set
      ovf <= ovf_set ? 1'b1 : (wr_ctrl && wdata_q[CTRL_OVF]) ? 1'b0 : ovf;
      IRQ <= ovf && ie;
      if (wr_ctrl) begin
        en <= wdata_q[CTRL_EN];
        ie <= wdata_q[CTRL_IE];
      end
      if (wr && addr_q == OFF_SCRATCH0) scratch0 <= wdata_q;
      if (wr && addr_q == OFF_SCRATCH1) scratch1 <= wdata_q;
      if (wr && addr_q == OFF_WAITCFG) waitcfg <= wdata_q[3:0];
    end
  always_comb begin
    rdata = addr_q == OFF_CTRL     ? 32'({ie, ovf, 1'b0, en}) :
            addr_q == OFF_SCRATCH0 ? scratch0 :
            addr_q == OFF_SCRATCH1 ? scratch1 :
            addr_q == OFF_ID       ? ID_VALUE :
            addr_q == OFF_CNT      ? 32'(cnt) :
            addr_q == OFF_WAITCFG  ? 32'(waitcfg) : 32'd0;
    PREADY  = state == IDLE || zero;
    PRDATA  = (state == ACCESS && !write_q && !err) ? DATAWIDTH'(rdata) : '0;
    PSLVERR = state == ACCESS && zero && err;
  end
endmodule

// File: doc/apb3_reg_completer.md
Name: apb3_reg_completer

Overview:
- APB3 completer (slave) register bank: the far end of the APB bus driven by the AHB-to-APB bridge.
- Decodes setup/access phases and inserts programmable wait states via PREADY.
- Flags illegal accesses with PSLVERR.
- Hosts control, scratch, ID and a free-running counter with a sticky overflow interrupt.

Parameters:
- ADDRWIDTH, 16, PADDR width; only PADDR[4:0] decoded, upper bits ignored.
- DATAWIDTH, 32, PRDATA/PWDATA width; fixed at 32 for this block.
- ID_VALUE, 32'hA3B0_0001, constant returned by ID register.

Ports:
- HCLK  in  1  single clock, shared with bridge.
- HRESETn  in  1  asynchronous active-low reset.
- PCLKEN  in  1  APB clock enable; APB-side state advances only when high.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDRWIDTH  byte address.
- PWDATA  in  32  write data.
- PREADY  out  1  transfer complete.
- PRDATA  out  32  read data.
- PSLVERR  out  1  error response.
- IRQ  out  1  CTRL.OVF & CTRL.IE.

Behaviour:
- Clock and reset: one clock HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: state IDLE, PREADY=1, PRDATA=0, PSLVERR=0, IRQ=0, all registers 0 except ID.
- Register map (word aligned):
  - 0x00 CTRL: [0] EN RW; [1] CLR write-1 pulse, reads 0; [2] OVF sticky W1C; [3] IE RW.
  - 0x04 SCRATCH0 RW.
  - 0x08 SCRATCH1 RW.
  - 0x0C ID RO.
  - 0x10 CNT RO.
  - 0x14 WAITCFG RW, [3:0] only, upper bits read 0.
- Error accesses: any other offset, PADDR[1:0]!=0, or a write to ID/CNT. Response is PSLVERR=1, PRDATA=0, no register change.
- FSM states: IDLE, ACCESS.
- IDLE:
  - PREADY=1.
  - On PCLKEN & PSEL & !PENABLE: latch PADDR, PWRITE, PWDATA; load wait_cnt=WAITCFG[3:0]; go to ACCESS.
  - PSEL & PENABLE seen in IDLE (no setup) is ignored.
- ACCESS:
  - PREADY = (wait_cnt==0).
  - On PCLKEN & PSEL & PENABLE with wait_cnt!=0: decrement wait_cnt.
  - With wait_cnt==0: commit the write (if legal) at this edge, return to IDLE.
  - Latency: setup cycle + (WAITCFG+1) access cycles, counted in PCLKEN-qualified cycles.
- Outputs during ACCESS:
  - PRDATA is driven from the latched address, combinationally, only in ACCESS for legal reads; otherwise 0.
  - PSLVERR is high only in ACCESS & PREADY & error; otherwise 0.
- Abort: PSEL low while in ACCESS (on a PCLKEN cycle) returns to IDLE with no write.
- PADDR/PWDATA changes during ACCESS are ignored (latched values used).
- WAITCFG write takes effect from the next transfer.
- CNT:
  - Increments every HCLK while EN=1, independent of PCLKEN.
  - Wraps 0xFFFF_FFFF to 0 and sets OVF.
- Simultaneous events:
  - CLR write and increment in the same cycle: CNT=0.
  - OVF set and W1C in the same cycle: set wins.
- IRQ is registered: asserts the cycle after OVF&IE becomes true.
- Reset mid-transfer: immediately IDLE, PREADY=1, the in-flight write is discarded.

Decomposition:
- Shared package apb_pkg holds:
  - register offset constants;
  - CTRL bit indices;
  - FSM state encodings (IDLE=1'b0, ACCESS=1'b1), in the same package as the bridge states.
- One natural sub-module, apb_wait_counter: loadable 4-bit down-counter with zero flag and PCLKEN gating.
- The register file stays inline.

Test Plan:
- Write 0x12345678 to 0x04 with WAITCFG=0, PCLKEN=1, then read 0x04 -> PREADY=1 in first access cycle, PRDATA=0x12345678, PSLVERR=0.
- Write WAITCFG=3, then read 0x0C -> PREADY low for 3 access cycles, high on 4th, PRDATA=0xA3B00001.
- Write 0x10; read 0x18; read 0x06 -> each completes with PSLVERR=1, PRDATA=0, no register change.
- Set CTRL=0x9, force CNT near wrap via long run (or reduced-width sim build) -> CNT wraps to 0, OVF=1, IRQ high next cycle; write CTRL=0xD (W1C OVF) -> OVF=0, IRQ low.
- PSEL deasserted mid-access with WAITCFG=2 during a write to 0x08 -> FSM back to IDLE, SCRATCH1 unchanged.
- PCLKEN toggling 1/0 during a WAITCFG=1 read -> wait count decrements only on PCLKEN=1 cycles; HRESETn pulsed mid-access -> PREADY=1, all registers at reset values.
